// File: rtl/max3421e_spi_responder.sv
// max3421e_spi_responder: SPI mode-0 slave modelling the MAX3421E register file, RCVFIFO and HIRQ/HIEN interrupt
module max3421e_spi_responder #(
  parameter int FIFO_DEPTH = 64,
  parameter int SYNC_STAGES = 2,
  parameter logic [4:0] RCVFIFO_ADDR = 5'd1,
  parameter logic [4:0] HIRQ_ADDR = 5'd25,
  parameter logic [4:0] HIEN_ADDR = 5'd26
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       spi_sclk,
  input  logic       spi_ss_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic       rx_push_valid,
  input  logic [7:0] rx_push_data,
  output logic       rx_push_ready,
  input  logic [7:0] irq_set,
  output logic       int_n,
  output logic       wr_strobe,
  output logic [4:0] wr_addr,
  output logic [7:0] wr_data
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_q, sclk_d, ss_q, ss_d, mosi_q, mosi_d;
  logic sclk_prev_q, sclk_prev_d, ss_prev_q, ss_prev_d;
  logic [2:0] bit_q, bit_d;
  logic [6:0] sh_q, sh_d;
  logic [7:0] miso_q, miso_d;
  logic [4:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic dir_q, dir_d, oe_q, oe_d, int_n_q, int_n_d, wr_strobe_q, wr_strobe_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] regs_q [32];
  logic [7:0] regs_d [32];
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [7:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] rd_q, rd_d, wp_q, wp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic sclk_s, ss_s, mosi_s, sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic byte_end, wr_hit, load, pop, push;
  logic [7:0] byte_in, clr;
  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign ss_s = ss_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ss_rise = ss_s & ~ss_prev_q;
  assign ss_fall = ~ss_s & ss_prev_q;
  assign byte_in = {sh_q, mosi_s};
  assign byte_end = state_q != IDLE && !ss_rise && sclk_rise && bit_q == 3'd7;
  assign wr_hit = byte_end && state_q == DATA && dir_q;
  assign load = state_q == DATA && !ss_rise && sclk_fall && bit_q == 3'd0;
  assign pop = load && !dir_q && addr_q == RCVFIFO_ADDR && cnt_q != '0;
  assign rx_push_ready = cnt_q != (AW+1)'(FIFO_DEPTH) || pop;
  assign push = rx_push_valid && rx_push_ready;
  assign clr = wr_hit && addr_q == HIRQ_ADDR ? byte_in : 8'h00;
  assign spi_miso = miso_q[7];
  assign spi_miso_oe = oe_q;
  assign int_n = int_n_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  always_comb begin
    sclk_d = SYNC_STAGES'({sclk_q, spi_sclk});
    ss_d = SYNC_STAGES'({ss_q, spi_ss_n});
    mosi_d = SYNC_STAGES'({mosi_q, spi_mosi});
    sclk_prev_d = sclk_s;
    ss_prev_d = ss_s;
    state_d = state_q;
    bit_d = bit_q;
    sh_d = sh_q;
    miso_d = miso_q;
    addr_d = addr_q;
    dir_d = dir_q;
    oe_d = oe_q;
    wr_strobe_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    regs_d = regs_q;
    mem_d = mem_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    wp_d = push ? wp_q + AW'(1) : wp_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    if (push) mem_d[wp_q] = rx_push_data;
    if (ss_rise) begin
      state_d = IDLE;
      oe_d = 1'b0;
      miso_d = 8'h00;
      bit_d = 3'd0;
    end else if (state_q == IDLE) begin
      if (ss_fall) begin
        state_d = CMD;
        oe_d = 1'b1;
        miso_d = regs_q[HIRQ_ADDR];
        bit_d = 3'd0;
      end
    end else begin
      if (sclk_rise) begin
        sh_d = byte_in[6:0];
        bit_d = bit_q + 3'd1;
      end
      if (byte_end && state_q == CMD) begin
        state_d = DATA;
        addr_d = byte_in[7:3];
        dir_d = byte_in[1];
      end
      if (wr_hit) begin
        wr_strobe_d = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = byte_in;
        if (addr_q != HIRQ_ADDR && addr_q != RCVFIFO_ADDR) regs_d[addr_q] = byte_in;
      end
      if (sclk_fall)
        miso_d = !load ? {miso_q[6:0], 1'b0} : dir_q ? 8'h00 :
                 addr_q != RCVFIFO_ADDR ? regs_q[addr_q] : pop ? mem_q[rd_q] : 8'h00;
    end
    regs_d[HIRQ_ADDR] = (regs_q[HIRQ_ADDR] & ~clr) | irq_set | {5'b0, cnt_d != '0, 2'b0};
    int_n_d = ~|(regs_q[HIRQ_ADDR] & regs_q[HIEN_ADDR]);
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sclk_q <= '0;
      ss_q <= '0;
      mosi_q <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q <= 1'b0;
      state_q <= IDLE;
      bit_q <= '0;
      sh_q <= '0;
      miso_q <= '0;
      addr_q <= '0;
      dir_q <= 1'b0;
      oe_q <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      regs_q <= '{default: '0};
      mem_q <= '{default: '0};
      rd_q <= '0;
      wp_q <= '0;
      cnt_q <= '0;
      int_n_q <= 1'b1;
    end else begin
      sclk_q <= sclk_d;
      ss_q <= ss_d;
      mosi_q <= mosi_d;
      sclk_prev_q <= sclk_prev_d;
      ss_prev_q <= ss_prev_d;
      state_q <= state_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      miso_q <= miso_d;
      addr_q <= addr_d;
      dir_q <= dir_d;
      oe_q <= oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      regs_q <= regs_d;
      mem_q <= mem_d;
      rd_q <= rd_d;
      wp_q <= wp_d;
      cnt_q <= cnt_d;
      int_n_q <= int_n_d;
    end
  end
endmodule

// File: tb/tb_max3421e_spi_responder.sv
// tb_max3421e_spi_responder: randomized self-checking bench against a transaction-level MAX3421E model
module tb_max3421e_spi_responder;
  logic Clk = 1'b0, Reset = 1'b1, spi_sclk = 1'b0, spi_ss_n = 1'b1, spi_mosi = 1'b0, rx_push_valid = 1'b0;
  logic [7:0] rx_push_data = 8'h00, irq_set = 8'h00;
  logic spi_miso, spi_miso_oe, rx_push_ready, int_n, wr_strobe;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  int errors = 0, checks = 0;
  logic [7:0] regs_m [32];
  logic [7:0] hirq_m = 8'h00;
  logic [7:0] q [$];
  logic [7:0] rxb [0:79];
  logic [7:0] expb [0:79];
  int strobes = 0, cyc = 0, strobe_cyc = 0, rise_cyc = 0;
  logic int_prev = 1'b1;
  logic [4:0] last_wa = '0;
  logic [7:0] last_wd = '0;
  max3421e_spi_responder dut (
    .Clk(Clk), .Reset(Reset), .spi_sclk(spi_sclk), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .rx_push_valid(rx_push_valid),
    .rx_push_data(rx_push_data), .rx_push_ready(rx_push_ready), .irq_set(irq_set), .int_n(int_n),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data)
  );
  always #5 Clk = ~Clk;
  always @(posedge Clk) begin
    cyc <= cyc + 1;
    int_prev <= int_n;
    if (int_n && !int_prev) rise_cyc <= cyc;
    if (wr_strobe) begin
      strobes <= strobes + 1;
      strobe_cyc <= cyc;
      last_wa <= wr_addr;
      last_wd <= wr_data;
    end
  end
  function automatic logic [7:0] pop_m();
    if (q.size() == 0) return 8'h00;
    return q.pop_front();
  endfunction
  function automatic void m_push(input logic [7:0] d);
    if (q.size() < 64) begin
      q.push_back(d);
      hirq_m[2] = 1'b1;
    end
  endfunction
  function automatic void m_write(input logic [4:0] a, input logic [7:0] d);
    if (a == 5'd25) begin
      hirq_m = hirq_m & ~d;
      if (q.size() != 0) hirq_m[2] = 1'b1;
    end else if (a != 5'd1) regs_m[a] = d;
  endfunction
  function automatic void m_read(input logic [4:0] a, input int n);
    for (int i = 0; i < n; i++) expb[i] = a == 5'd1 ? pop_m() : a == 5'd25 ? hirq_m : regs_m[a];
    if (a == 5'd1) void'(pop_m());
  endfunction
  function automatic logic exp_int_n();
    return ~|(hirq_m & regs_m[26]);
  endfunction
  task automatic spi_begin();
    @(negedge Clk) spi_ss_n = 1'b0;
    repeat (6) @(negedge Clk);
  endtask
  task automatic spi_end();
    repeat (6) @(negedge Clk);
    spi_ss_n = 1'b1;
    repeat (6) @(negedge Clk);
  endtask
  task automatic spi_byte(input logic [7:0] b, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = b[7-i];
      repeat (6) @(negedge Clk);
      r[7-i] = spi_miso;
      spi_sclk = 1'b1;
      repeat (6) @(negedge Clk);
      spi_sclk = 1'b0;
    end
  endtask
  task automatic wr_txn(input logic [4:0] a, input logic [7:0] d, output logic [7:0] st, output int ns);
    int s0;
    logic [7:0] r;
    s0 = strobes;
    spi_begin();
    spi_byte({a, 3'b010}, 8, st);
    spi_byte(d, 8, r);
    spi_end();
    ns = strobes - s0;
  endtask
  task automatic rd_txn(input logic [4:0] a, input int n, output logic [7:0] st);
    logic [7:0] r;
    spi_begin();
    spi_byte({a, 3'b000}, 8, st);
    for (int i = 0; i < n; i++) begin
      spi_byte(8'h00, 8, r);
      rxb[i] = r;
    end
    spi_end();
  endtask
  task automatic drv_push(input logic [7:0] d);
    @(negedge Clk) begin rx_push_valid = 1'b1; rx_push_data = d; end
    @(negedge Clk) rx_push_valid = 1'b0;
  endtask
  task automatic drv_irq(input logic [7:0] v);
    @(negedge Clk) irq_set = v;
    @(negedge Clk) irq_set = 8'h00;
    hirq_m = hirq_m | v;
  endtask
  task automatic test_reset();
    checks += 7;
    if (spi_miso !== 1'b0) begin errors++; $display("FAIL rst_miso got=%b exp=0", spi_miso); end
    if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL rst_oe got=%b exp=0", spi_miso_oe); end
    if (rx_push_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", rx_push_ready); end
    if (int_n !== 1'b1) begin errors++; $display("FAIL rst_int_n got=%b exp=1", int_n); end
    if (wr_strobe !== 1'b0) begin errors++; $display("FAIL rst_wr_strobe got=%b exp=0", wr_strobe); end
    if (wr_addr !== 5'd0) begin errors++; $display("FAIL rst_wr_addr got=%h exp=0", wr_addr); end
    if (wr_data !== 8'h00) begin errors++; $display("FAIL rst_wr_data got=%h exp=0", wr_data); end
  endtask
  task automatic test_write_read();
    logic [7:0] st, est;
    int ns;
    est = hirq_m;
    wr_txn(5'd26, 8'h04, st, ns);
    m_write(5'd26, 8'h04);
    checks += 4;
    if (st !== est) begin errors++; $display("FAIL wr_status got=%h exp=%h", st, est); end
    if (ns !== 1) begin errors++; $display("FAIL wr_strobe_count got=%0d exp=1", ns); end
    if (last_wa !== 5'd26) begin errors++; $display("FAIL wr_addr got=%0d exp=26", last_wa); end
    if (last_wd !== 8'h04) begin errors++; $display("FAIL wr_data got=%h exp=04", last_wd); end
    est = hirq_m;
    rd_txn(5'd26, 1, st);
    m_read(5'd26, 1);
    checks += 2;
    if (st !== est) begin errors++; $display("FAIL rd_status got=%h exp=%h", st, est); end
    if (rxb[0] !== expb[0]) begin errors++; $display("FAIL rd_hien got=%h exp=%h", rxb[0], expb[0]); end
  endtask
  task automatic test_fifo_read();
    logic [7:0] st;
    drv_push(8'h11); m_push(8'h11);
    drv_push(8'h22); m_push(8'h22);
    drv_push(8'h33); m_push(8'h33);
    drv_irq(8'h00);
    rd_txn(5'd1, 4, st);
    m_read(5'd1, 4);
    checks++;
    if (st !== 8'h04) begin errors++; $display("FAIL fifo_status got=%h exp=04", st); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rxb[i] !== expb[i]) begin errors++; $display("FAIL fifo_byte%0d got=%h exp=%h", i, rxb[i], expb[i]); end
    end
  endtask
  task automatic test_int();
    logic [7:0] st;
    int ns;
    drv_push(8'h55); m_push(8'h55);
    repeat (3) @(negedge Clk);
    checks++;
    if (int_n !== exp_int_n()) begin errors++; $display("FAIL int_low got=%b exp=%b", int_n, exp_int_n()); end
    rd_txn(5'd1, 1, st);
    m_read(5'd1, 1);
    checks++;
    if (rxb[0] !== expb[0]) begin errors++; $display("FAIL int_drain got=%h exp=%h", rxb[0], expb[0]); end
    wr_txn(5'd25, 8'h04, st, ns);
    m_write(5'd25, 8'h04);
    checks += 3;
    if (int_n !== exp_int_n()) begin errors++; $display("FAIL int_high got=%b exp=%b", int_n, exp_int_n()); end
    if (ns !== 1 || last_wa !== 5'd25) begin errors++; $display("FAIL w1c_strobe got=%0d/%0d exp=1/25", ns, last_wa); end
    if (rise_cyc - strobe_cyc !== 1) begin errors++; $display("FAIL int_latency got=%0d exp=1", rise_cyc - strobe_cyc); end
    rd_txn(5'd25, 1, st);
    m_read(5'd25, 1);
    checks += 2;
    if (st !== 8'h00) begin errors++; $display("FAIL w1c_status got=%h exp=00", st); end
    if (rxb[0] !== expb[0]) begin errors++; $display("FAIL w1c_hirq got=%h exp=%h", rxb[0], expb[0]); end
  endtask
  task automatic test_full();
    logic [7:0] st, x, y, e0;
    for (int i = 0; i < 64; i++) begin
      x = 8'($urandom);
      drv_push(x);
      m_push(x);
    end
    checks++;
    if (rx_push_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", rx_push_ready); end
    y = 8'($urandom);
    @(negedge Clk) begin rx_push_valid = 1'b1; rx_push_data = y; end
    checks++;
    if (rx_push_ready !== 1'b0) begin errors++; $display("FAIL push65_ready got=%b exp=0", rx_push_ready); end
    @(negedge Clk) rx_push_valid = 1'b0;
    x = 8'($urandom);
    @(negedge Clk) begin rx_push_valid = 1'b1; rx_push_data = x; end
    rd_txn(5'd1, 1, st);
    @(negedge Clk) rx_push_valid = 1'b0;
    e0 = q.pop_front();
    q.push_back(x);
    void'(q.pop_front());
    q.push_back(x);
    checks += 2;
    if (rxb[0] !== e0) begin errors++; $display("FAIL full_pop got=%h exp=%h", rxb[0], e0); end
    if (rx_push_ready !== 1'b0) begin errors++; $display("FAIL full_after_swap got=%b exp=0", rx_push_ready); end
    rd_txn(5'd1, 64, st);
    m_read(5'd1, 64);
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (rxb[i] !== expb[i]) begin errors++; $display("FAIL drain_byte%0d got=%h exp=%h", i, rxb[i], expb[i]); end
    end
    rd_txn(5'd1, 1, st);
    m_read(5'd1, 1);
    checks += 2;
    if (rxb[0] !== 8'h00) begin errors++; $display("FAIL empty_read got=%h exp=00", rxb[0]); end
    if (rx_push_ready !== 1'b1) begin errors++; $display("FAIL empty_ready got=%b exp=1", rx_push_ready); end
  endtask
  task automatic test_abort();
    logic [7:0] st, r;
    int s0;
    s0 = strobes;
    spi_begin();
    spi_byte(8'h3A, 8, st);
    spi_byte(8'($urandom) | 8'h81, 5, r);
    spi_end();
    checks += 3;
    if (strobes - s0 !== 0) begin errors++; $display("FAIL abort_strobe got=%0d exp=0", strobes - s0); end
    if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL abort_oe got=%b exp=0", spi_miso_oe); end
    if (spi_miso !== 1'b0) begin errors++; $display("FAIL abort_miso got=%b exp=0", spi_miso); end
    rd_txn(5'd7, 1, st);
    m_read(5'd7, 1);
    checks++;
    if (rxb[0] !== expb[0]) begin errors++; $display("FAIL abort_reg7 got=%h exp=%h", rxb[0], expb[0]); end
  endtask
  task automatic test_random();
    logic [7:0] st, est, d;
    logic [4:0] a;
    int n, ns, op;
    for (int it = 0; it < 30; it++) begin
      op = $urandom_range(0, 4);
      if (op == 0) begin
        a = 5'($urandom);
        d = 8'($urandom);
        est = hirq_m;
        wr_txn(a, d, st, ns);
        m_write(a, d);
        checks += 2;
        if (st !== est) begin errors++; $display("FAIL rnd_wr_status it=%0d got=%h exp=%h", it, st, est); end
        if (ns !== 1 || last_wa !== a || last_wd !== d) begin
          errors++; $display("FAIL rnd_wr it=%0d got=%0d/%0d/%h exp=1/%0d/%h", it, ns, last_wa, last_wd, a, d);
        end
      end else if (op == 1 || op == 4) begin
        a = op == 4 ? 5'd1 : 5'($urandom);
        n = $urandom_range(1, 4);
        est = hirq_m;
        rd_txn(a, n, st);
        m_read(a, n);
        checks++;
        if (st !== est) begin errors++; $display("FAIL rnd_rd_status it=%0d got=%h exp=%h", it, st, est); end
        for (int i = 0; i < n; i++) begin
          checks++;
          if (rxb[i] !== expb[i]) begin errors++; $display("FAIL rnd_rd it=%0d addr=%0d byte%0d got=%h exp=%h", it, a, i, rxb[i], expb[i]); end
        end
      end else if (op == 2) begin
        n = $urandom_range(1, 5);
        for (int i = 0; i < n; i++) begin
          d = 8'($urandom);
          drv_push(d);
          m_push(d);
        end
      end else drv_irq(8'($urandom));
      repeat (3) @(negedge Clk);
      checks++;
      if (int_n !== exp_int_n()) begin errors++; $display("FAIL rnd_int_n it=%0d got=%b exp=%b", it, int_n, exp_int_n()); end
    end
  endtask
  task automatic test_reset_mid();
    logic [7:0] st, r;
    drv_push(8'hA5); m_push(8'hA5);
    drv_irq(8'h81);
    spi_begin();
    spi_byte(8'h08, 8, st);
    spi_byte(8'h00, 3, r);
    @(negedge Clk) Reset = 1'b1;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    regs_m = '{default: '0};
    hirq_m = 8'h00;
    q.delete();
    checks += 4;
    if (int_n !== 1'b1) begin errors++; $display("FAIL midrst_int_n got=%b exp=1", int_n); end
    if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL midrst_oe got=%b exp=0", spi_miso_oe); end
    if (spi_miso !== 1'b0) begin errors++; $display("FAIL midrst_miso got=%b exp=0", spi_miso); end
    if (rx_push_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", rx_push_ready); end
    repeat (6) @(negedge Clk);
    spi_ss_n = 1'b1;
    repeat (6) @(negedge Clk);
    rd_txn(5'd26, 1, st);
    checks += 2;
    if (st !== 8'h00) begin errors++; $display("FAIL midrst_status got=%h exp=00", st); end
    if (rxb[0] !== 8'h00) begin errors++; $display("FAIL midrst_hien got=%h exp=00", rxb[0]); end
    rd_txn(5'd1, 1, st);
    checks++;
    if (rxb[0] !== 8'h00) begin errors++; $display("FAIL midrst_fifo got=%h exp=00", rxb[0]); end
  endtask
  initial begin
    regs_m = '{default: '0};
    repeat (4) @(negedge Clk);
    Reset = 1'b0;
    repeat (4) @(negedge Clk);
    test_reset();
    test_write_read();
    test_fifo_read();
    test_int();
    test_full();
    test_abort();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
